param_stack: RTL and testbench

//  Parametrised hardware operand stack for the multi-cycle stack MIPS datapath.

---
 rtl/param_stack_pkg.sv | 30 +++
 rtl/param_stack_ram.sv | 25 ++
 rtl/param_stack.sv | 91 +++++++++
 tb/tb_param_stack.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the parametrised operand stack.
// The op encoding is the resolved action for one edge after error/saturation rules apply.
package param_stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // push+pop on an empty stack degrades to a plain push; blocked requests become idle.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic empty, input logic full);
    stack_op_e op;
    op = OP_IDLE;
    if (push && pop)
      op = empty ? OP_PUSH : OP_REPLACE;
    else if (push && !full)
      op = OP_PUSH;
    else if (pop && !empty)
      op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/param_stack_ram.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
// No reset on the array; contents are don't-care until written.
module param_stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack: count, sticky error flags, registered top-of-stack read.
// Storage lives in param_stack_ram; this module owns all control state.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] d_out_reg;
  logic             overflow_reg, underflow_reg;
  logic             ovf_set, unf_set;
  stack_op_e        op;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  assign op = decode_op(push, pop, empty, full);

  // raddr is garbage when empty; every consumer masks that case.
  assign raddr = AW'(count_reg - CW'(1));
  assign we    = (op == OP_PUSH) || (op == OP_REPLACE);
  assign waddr = (op == OP_REPLACE) ? raddr : AW'(count_reg);

  assign ovf_set = push && !pop && full;
  assign unf_set = (pop || tos) && empty;

  always_comb begin
    count_next = count_reg;
    case (op)
      OP_PUSH: count_next = count_reg + CW'(1);
      OP_POP:  count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  param_stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(d_in),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      d_out_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (tos)
        d_out_reg <= empty ? '0 : rdata;
      // A fresh error in the same cycle as clr_err leaves the flag set.
      overflow_reg  <= ovf_set || (overflow_reg && !clr_err);
      underflow_reg <= unf_set || (underflow_reg && !clr_err);
    end
  end

  assign count     = count_reg;
  assign d_out     = d_out_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: 8x4 instance (a) and 16x8 instance (b).
// Expected values are queued as each step is driven and compared after the edge.
module tb_param_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       push_a, pop_a, tos_a, clr_a;
  logic [7:0] d_in_a, d_out_a;
  logic [2:0] count_a;
  logic       empty_a, full_a, ovf_a, unf_a;

  logic        push_b, pop_b, tos_b, clr_b;
  logic [15:0] d_in_b, d_out_b;
  logic [3:0]  count_b;
  logic        empty_b, full_b, ovf_b, unf_b;

  param_stack #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .tos(tos_a), .clr_err(clr_a),
    .d_in(d_in_a), .d_out(d_out_a), .count(count_a), .empty(empty_a), .full(full_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  param_stack #(.WIDTH(16), .DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .tos(tos_b), .clr_err(clr_b),
    .d_in(d_in_b), .d_out(d_out_b), .count(count_b), .empty(empty_b), .full(full_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(input string tag);
    if (tag == "a_cnt")   return 32'(count_a);
    if (tag == "a_dout")  return 32'(d_out_a);
    if (tag == "a_empty") return 32'(empty_a);
    if (tag == "a_full")  return 32'(full_a);
    if (tag == "a_ovf")   return 32'(ovf_a);
    if (tag == "a_unf")   return 32'(unf_a);
    if (tag == "b_cnt")   return 32'(count_b);
    if (tag == "b_dout")  return 32'(d_out_b);
    if (tag == "b_full")  return 32'(full_b);
    if (tag == "b_ovf")   return 32'(ovf_b);
    return 'x;
  endfunction

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.tag);
      n_cmp++;
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
      $display("check %-7s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    push_a = 0; pop_a = 0; tos_a = 0; clr_a = 0; d_in_a = '0;
    push_b = 0; pop_b = 0; tos_b = 0; clr_b = 0; d_in_b = '0;
  endtask

  task automatic drive(input bit sel_b, input logic pu, input logic po, input logic t,
                       input logic c, input logic [15:0] d);
    @(negedge clk);
    idle();
    if (!sel_b) begin
      push_a = pu; pop_a = po; tos_a = t; clr_a = c; d_in_a = d[7:0];
    end else begin
      push_b = pu; pop_b = po; tos_b = t; clr_b = c; d_in_b = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    drain();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst = 1'b0;
    #1 drain();
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_v("a_cnt", 0); expect_v("a_dout", 0); expect_v("a_empty", 1);
    expect_v("a_full", 0); expect_v("a_ovf", 0); expect_v("a_unf", 0);
    expect_v("b_cnt", 0); expect_v("b_dout", 0);
    drain();
    @(negedge clk) rst = 1'b1;

    // 1: push three, read top, pop, read new top
    drive(0, 1, 0, 0, 0, 16'h11); tick();
    drive(0, 1, 0, 0, 0, 16'h22); tick();
    drive(0, 1, 0, 0, 0, 16'h33); expect_v("a_cnt", 3); expect_v("a_full", 0); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h33); tick();
    drive(0, 0, 1, 0, 0, 0);      expect_v("a_cnt", 2); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h22); tick();

    // 2: fill to full, overflow on fifth push
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 16'(8'h41 + i)); tick();
    end
    drive(0, 1, 0, 0, 0, 16'h44); expect_v("a_cnt", 4); expect_v("a_full", 1); tick();
    drive(0, 1, 0, 0, 0, 16'h55); expect_v("a_cnt", 4); expect_v("a_ovf", 1); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h44); expect_v("a_ovf", 1); tick();

    // 3: drain to empty, underflow, clear, clear racing a new error
    drive(0, 0, 0, 0, 1, 0); expect_v("a_ovf", 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0); tick();
    end
    expect_v("a_cnt", 0); expect_v("a_empty", 1); expect_v("a_unf", 0); drain();
    drive(0, 0, 1, 0, 0, 0); expect_v("a_unf", 1); expect_v("a_cnt", 0); tick();
    drive(0, 0, 0, 1, 0, 0); expect_v("a_dout", 0); tick();
    drive(0, 0, 0, 0, 1, 0); expect_v("a_unf", 0); tick();
    drive(0, 0, 1, 0, 1, 0); expect_v("a_unf", 1); expect_v("a_cnt", 0); tick();

    // 4: replace on non-empty, then push+pop on empty
    reset_pulse();
    drive(0, 1, 0, 0, 0, 16'h11); tick();
    drive(0, 1, 0, 0, 0, 16'h22); tick();
    drive(0, 1, 1, 0, 0, 16'h99); expect_v("a_cnt", 2); expect_v("a_unf", 0); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h99); tick();
    drive(0, 0, 1, 1, 0, 0);      expect_v("a_dout", 8'h99); expect_v("a_cnt", 1); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h11); tick();
    reset_pulse();
    drive(0, 1, 1, 0, 0, 16'h77); expect_v("a_cnt", 1); expect_v("a_unf", 1); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h77); tick();

    // 5: pop-and-read, push-and-read returns the old top
    reset_pulse();
    drive(0, 1, 0, 0, 0, 16'hA0); tick();
    drive(0, 1, 0, 0, 0, 16'hB0); tick();
    drive(0, 0, 1, 1, 0, 0);      expect_v("a_dout", 8'hB0); expect_v("a_cnt", 1); tick();
    drive(0, 1, 0, 1, 0, 16'hC0); expect_v("a_dout", 8'hA0); expect_v("a_cnt", 2); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'hC0); tick();

    // 6: async reset mid-cycle with flags set and a request in flight
    reset_pulse();
    drive(0, 0, 1, 0, 0, 0);      expect_v("a_unf", 1); tick();
    drive(0, 1, 0, 0, 0, 16'h01); tick();
    drive(0, 1, 0, 0, 0, 16'h02); tick();
    drive(0, 1, 0, 0, 0, 16'h03); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h03); expect_v("a_cnt", 3); tick();
    @(posedge clk);
    #3 rst = 1'b0;
    push_a = 1'b1; d_in_a = 8'hEE;
    expect_v("a_cnt", 0); expect_v("a_dout", 0); expect_v("a_unf", 0);
    expect_v("a_ovf", 0); expect_v("a_empty", 1);
    #1 drain();
    @(posedge clk);
    #1 expect_v("a_cnt", 0); drain();
    @(negedge clk);
    rst = 1'b1;
    idle();
    drive(0, 1, 0, 0, 0, 16'h01); expect_v("a_cnt", 1); tick();
    drive(0, 0, 0, 1, 0, 0);      expect_v("a_dout", 8'h01); tick();

    // 16x8 instance: tests 1 and 2
    reset_pulse();
    drive(1, 1, 0, 0, 0, 16'h1111); tick();
    drive(1, 1, 0, 0, 0, 16'h2222); tick();
    drive(1, 1, 0, 0, 0, 16'h3333); expect_v("b_cnt", 3); tick();
    drive(1, 0, 0, 1, 0, 0);        expect_v("b_dout", 16'h3333); tick();
    drive(1, 0, 1, 0, 0, 0);        expect_v("b_cnt", 2); tick();
    drive(1, 0, 0, 1, 0, 0);        expect_v("b_dout", 16'h2222); tick();
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 0, 0, 0, 16'hA000 + 16'(i)); tick();
    end
    drive(1, 1, 0, 0, 0, 16'hA007); expect_v("b_cnt", 8); expect_v("b_full", 1); tick();
    drive(1, 1, 0, 0, 0, 16'h5555); expect_v("b_cnt", 8); expect_v("b_ovf", 1); tick();
    drive(1, 0, 0, 1, 0, 0);        expect_v("b_dout", 16'hA007); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
